// File: rtl/fsm_step_seq_if.sv
// fsm_step_seq_if: frame request handshake, downstream FSM control and status bundle
interface fsm_step_seq_if #(parameter int LEN_W = 8, parameter int CNT_W = 16);
    logic req_valid;
    logic req_ready;
    logic [LEN_W-1:0] req_len;
    logic [2:0] fsm_out;
    logic err_clr;
    logic start;
    logic step2;
    logic step3;
    logic busy;
    logic done;
    logic err;
    logic [CNT_W-1:0] frm_cnt;
    modport master (
        output req_valid, req_len, fsm_out, err_clr,
        input req_ready, start, step2, step3, busy, done, err, frm_cnt
    );
    modport slave (
        input req_valid, req_len, fsm_out, err_clr,
        output req_ready, start, step2, step3, busy, done, err, frm_cnt
    );
endinterface

// File: rtl/fsm_step_seq.sv
// fsm_step_seq: frame sequencer driving a 4-phase control FSM, with phase-mismatch detection and recovery
module fsm_step_seq #(
    parameter int LEN_W = 8,
    parameter int GAP_CYC = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    fsm_step_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, WAIT, CHK, DATA, GAP, ERR} state_t;
    localparam int GW = $clog2(GAP_CYC + 2);
    localparam state_t POST = (GAP_CYC == 0) ? IDLE : GAP;
    state_t state, state_nx;
    logic [LEN_W-1:0] len_q, cnt;
    logic [GW-1:0] gap_q;
    logic err_q, done_q, mismatch, fin;
    logic [CNT_W-1:0] frm_q;
    logic [2:0] exp_code;
    always_comb begin
        exp_code = state == WAIT ? 3'b010 : state == CHK ? 3'b100 : state == DATA ? 3'b111 : 3'b001;
        mismatch = state != ERR && bus.fsm_out != exp_code;
        fin = (state == DATA && cnt == LEN_W'(1)) || (state == CHK && len_q == '0);
        state_nx = state;
        case (state)
            IDLE: if (bus.req_valid && !err_q) state_nx = START;
            START: state_nx = WAIT;
            WAIT: state_nx = CHK;
            CHK: state_nx = len_q != '0 ? DATA : POST;
            DATA: if (cnt == LEN_W'(1)) state_nx = POST;
            GAP: if (gap_q == '0) state_nx = IDLE;
            ERR: if (bus.fsm_out == 3'b001) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // a phase divergence wins over every other transition
        if (mismatch) state_nx = ERR;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            len_q <= '0;
            cnt <= '0;
            gap_q <= '0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            frm_q <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == START) len_q <= bus.req_len;
            if (state == CHK) cnt <= len_q;
            else if (state == DATA) cnt <= cnt - LEN_W'(1);
            gap_q <= state == GAP ? gap_q - GW'(1) : GW'(GAP_CYC - 1);
            err_q <= mismatch | (err_q & ~bus.err_clr);
            done_q <= fin & ~mismatch;
            if (fin && !mismatch) frm_q <= frm_q + CNT_W'(1);
        end
    end
    assign bus.req_ready = state == IDLE && !err_q;
    assign bus.start = state == START;
    assign bus.step2 = state == CHK && len_q != '0;
    assign bus.step3 = state == ERR || (state == DATA && cnt == LEN_W'(1));
    assign bus.busy = state != IDLE;
    assign bus.done = done_q;
    assign bus.err = err_q;
    assign bus.frm_cnt = frm_q;
endmodule

// File: tb/tb_fsm_step_seq.sv
// tb_fsm_step_seq: vector table with frame scoreboard plus hand-written error, reset and wrap sequences
module tb_fsm_step_seq;
    logic clk = 1'b0;
    logic reset;
    int n_pass = 0;
    int n_tot = 0;
    logic fa_force;
    logic [2:0] fa_val;
    logic [2:0] fm_a, fm_b;
    logic mon_en = 1'b0;
    typedef struct {
        logic [7:0] len;
        int s2_cyc;
        int s3_cyc;
        int s3_n;
        int data_n;
        int done_cyc;
        int ready_cyc;
        int cnt;
    } vec_t;
    vec_t vecs[5];
    vec_t exp_q[$];

    fsm_step_seq_if #(.LEN_W(8), .CNT_W(16)) a();
    fsm_step_seq_if #(.LEN_W(8), .CNT_W(4)) b();

    fsm_step_seq #(.LEN_W(8), .GAP_CYC(4), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    fsm_step_seq #(.LEN_W(8), .GAP_CYC(0), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

    always #5 clk = ~clk;

    // downstream 4-phase FSM: idle 001, start 010, check 100, payload 111
    function automatic logic [2:0] fsm_nx(input logic [2:0] s, input logic st, input logic s2, input logic s3);
        return s == 3'b001 ? (st ? 3'b010 : 3'b001) :
               s == 3'b010 ? 3'b100 :
               s == 3'b100 ? (s2 ? 3'b111 : 3'b001) :
               s == 3'b111 ? (s3 ? 3'b001 : 3'b111) : 3'b001;
    endfunction

    always_ff @(posedge clk) begin
        fm_a <= !reset ? 3'b001 : fsm_nx(fm_a, a.start, a.step2, a.step3);
        fm_b <= !reset ? 3'b001 : fsm_nx(fm_b, b.start, b.step2, b.step3);
    end
    assign a.fsm_out = fa_force ? fa_val : fm_a;
    assign b.fsm_out = fm_b;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic send_a(input logic [7:0] len);
        int n = 0;
        a.req_len = len;
        a.req_valid = 1'b1;
        while (!a.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept", int'(a.req_ready), 1);
        @(negedge clk);
        a.req_valid = 1'b0;
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!a.req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_wait", int'(a.req_ready), 1);
    endtask

    task automatic frame_b(input logic [7:0] len, output int k);
        b.req_len = len;
        b.req_valid = 1'b1;
        @(negedge clk);
        b.req_valid = 1'b0;
        k = 1;
        while (!b.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    // frame monitor: measures cycle positions relative to the start pulse, compares against scoreboard
    initial begin : mon
        int rel, o_s2, o_s3, o_s3n, o_dn, o_done, o_cnt, o_err;
        logic act;
        vec_t e;
        act = 1'b0;
        rel = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) act = 1'b0;
            else begin
                if (a.start) begin
                    act = 1'b1;
                    rel = 1;
                    o_s2 = 0; o_s3 = 0; o_s3n = 0; o_dn = 0; o_done = 0; o_cnt = -1; o_err = 0;
                end else if (act) rel++;
                if (act) begin
                    if (a.step2) o_s2 = rel;
                    if (a.step3) begin
                        o_s3 = rel;
                        o_s3n++;
                    end
                    if (fm_a == 3'b111) o_dn++;
                    if (a.done) begin
                        o_done = rel;
                        o_cnt = int'(a.frm_cnt);
                    end
                    if (a.err) o_err = 1;
                    if (a.req_ready) begin
                        act = 1'b0;
                        if (exp_q.size() == 0) chk("sb_pop", 0, 1);
                        else begin
                            e = exp_q.pop_front();
                            chk("sb_step2_cyc", o_s2, e.s2_cyc);
                            chk("sb_step3_cyc", o_s3, e.s3_cyc);
                            chk("sb_step3_n", o_s3n, e.s3_n);
                            chk("sb_data_n", o_dn, e.data_n);
                            chk("sb_done_cyc", o_done, e.done_cyc);
                            chk("sb_frm_cnt", o_cnt, e.cnt);
                            chk("sb_ready_cyc", rel, e.ready_cyc);
                            chk("sb_no_err", o_err, 0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        int k;
        vecs[0] = '{8'd3, 3, 6, 1, 3, 7, 11, 1};
        vecs[1] = '{8'd0, 0, 0, 0, 0, 4, 8, 2};
        vecs[2] = '{8'd1, 3, 4, 1, 1, 5, 9, 3};
        vecs[3] = '{8'd255, 3, 258, 1, 255, 259, 263, 4};
        vecs[4] = '{8'd2, 3, 5, 1, 2, 6, 10, 5};
        reset = 1'b0;
        fa_force = 1'b0;
        fa_val = 3'b001;
        b.req_valid = 1'b0;
        b.req_len = '0;
        b.err_clr = 1'b0;
        repeat (2) begin
            a.req_valid = 1'($urandom);
            a.req_len = 8'($urandom);
            a.err_clr = 1'($urandom);
            fa_force = 1'b1;
            fa_val = 3'($urandom);
            @(negedge clk);
        end
        chk("rst_start", int'(a.start), 0);
        chk("rst_step2", int'(a.step2), 0);
        chk("rst_step3", int'(a.step3), 0);
        chk("rst_busy", int'(a.busy), 0);
        chk("rst_done", int'(a.done), 0);
        chk("rst_err", int'(a.err), 0);
        chk("rst_frm_cnt", int'(a.frm_cnt), 0);
        chk("rst_ready", int'(a.req_ready), 1);
        a.req_valid = 1'b0;
        a.err_clr = 1'b0;
        fa_force = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", int'(a.req_ready), 1);
        chk("rel_busy", int'(a.busy), 0);

        mon_en = 1'b1;
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i]);
            send_a(vecs[i].len);
            wait_ready_a();
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk("sb_empty", exp_q.size(), 0);

        // phase mismatch in CHK, recovery, then clear
        send_a(8'd3);
        repeat (2) @(negedge clk);
        chk("chk_step2", int'(a.step2), 1);
        fa_force = 1'b1;
        fa_val = 3'b001;
        @(negedge clk);
        chk("err_busy", int'(a.busy), 1);
        chk("err_flag", int'(a.err), 1);
        chk("err_step3", int'(a.step3), 1);
        chk("err_start", int'(a.start), 0);
        chk("err_step2", int'(a.step2), 0);
        @(negedge clk);
        fa_force = 1'b0;
        chk("err_idle_busy", int'(a.busy), 0);
        chk("err_idle_ready", int'(a.req_ready), 0);
        chk("err_sticky", int'(a.err), 1);
        a.req_valid = 1'b1;
        a.err_clr = 1'b1;
        @(negedge clk);
        a.req_valid = 1'b0;
        a.err_clr = 1'b0;
        chk("clr_err", int'(a.err), 0);
        chk("clr_ready", int'(a.req_ready), 1);
        chk("no_accept_in_err", int'(a.busy), 0);

        // stuck payload code after a mismatch
        fa_force = 1'b1;
        fa_val = 3'b010;
        @(negedge clk);
        chk("stuck_err", int'(a.err), 1);
        fa_val = 3'b111;
        for (int i = 0; i < 3; i++) begin
            chk("stuck_step3", int'(a.step3), 1);
            chk("stuck_busy", int'(a.busy), 1);
            @(negedge clk);
        end
        fa_val = 3'b001;
        chk("stuck_last_step3", int'(a.step3), 1);
        @(negedge clk);
        chk("stuck_idle", int'(a.busy), 0);
        fa_val = 3'b100;
        a.err_clr = 1'b1;
        @(negedge clk);
        chk("set_wins_err", int'(a.err), 1);
        chk("set_wins_busy", int'(a.busy), 1);
        fa_val = 3'b001;
        a.err_clr = 1'b0;
        @(negedge clk);
        chk("set_wins_idle", int'(a.busy), 0);
        chk("set_wins_ready", int'(a.req_ready), 0);
        fa_force = 1'b0;
        a.err_clr = 1'b1;
        @(negedge clk);
        a.err_clr = 1'b0;
        chk("final_clr", int'(a.err), 0);

        // reset in cycle 5 of a frame
        chk("pre_rst_cnt", int'(a.frm_cnt), 5);
        send_a(8'd5);
        repeat (4) @(negedge clk);
        chk("mid_busy", int'(a.busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_busy", int'(a.busy), 0);
        chk("mid_rst_cnt", int'(a.frm_cnt), 0);
        chk("mid_rst_ready", int'(a.req_ready), 1);
        chk("mid_rst_step3", int'(a.step3), 0);

        // GAP_CYC=0 build and 4-bit frame counter wrap
        chk("b_ready0", int'(b.req_ready), 1);
        frame_b(8'd2, k);
        chk("b_gap0_ready_cyc", k, 6);
        chk("b_gap0_done", int'(b.done), 1);
        chk("b_gap0_cnt", int'(b.frm_cnt), 1);
        for (int f = 0; f < 15; f++) begin
            frame_b(8'd0, k);
            chk("b_hdr_ready_cyc", k, 4);
            chk("b_hdr_cnt", int'(b.frm_cnt), (f + 2) % 16);
        end
        chk("b_wrap_done", int'(b.done), 1);
        chk("b_no_err", int'(b.err), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/fsm_step_seq.md
# fsm_step_seq

Frame sequencer that sits directly upstream of the 4-phase control FSM. It drives that FSM's `start`, `step2` and `step3` inputs. Frame requests arrive on a valid/ready handshake. The block monitors the FSM's `fsm_out` phase code every cycle and flags any divergence as a sticky error, then recovers the FSM to its idle phase.

## Interface
- `LEN_W`, 8: width of `req_len` and of the payload down-counter.
- `GAP_CYC`, 4: mandatory idle cycles after each frame before the next request is accepted. 0 is legal.
- `CNT_W`, 16: width of the `frm_cnt` completed-frame counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. All registers are cleared on the rising edge of `clk` while low.
- `req_valid` in 1: frame request present.
- `req_ready` out 1: block can accept a request.
- `req_len` in LEN_W: payload length in cycles. 0 means a header-only frame with `step2` driven low.
- `fsm_out` in 3: phase code from the downstream FSM. Codes: 001 idle, 010 start, 100 check, 111 payload.
- `err_clr` in 1: one-cycle pulse that clears `err`.
- `start` out 1: to downstream FSM.
- `step2` out 1: to downstream FSM.
- `step3` out 1: to downstream FSM.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a frame completes.
- `err` out 1: sticky phase-mismatch flag.
- `frm_cnt` out CNT_W: count of completed frames; wraps modulo 2^CNT_W.

## Operation
States: IDLE, START, WAIT, CHK, DATA, GAP, ERR. Each state has an expected `fsm_out` code:
- IDLE: expects 001. `req_ready` = !`err`. On `req_valid` && `req_ready`: latch `req_len` into `len_q`, go to START.
- START: `start`=1, expects 001, go to WAIT.
- WAIT: expects 010, go to CHK.
- CHK: expects 100. `step2` = (`len_q` != 0).
  - If `len_q` != 0: load `cnt` = `len_q`, go to DATA.
  - Otherwise go to GAP.
- DATA: expects 111. `cnt` decrements each cycle. `step3`=1 when `cnt`==1, then go to GAP.
- GAP: expects 001. Stays for GAP_CYC cycles, then goes to IDLE. When GAP_CYC=0, DATA/CHK go directly to IDLE and `done` still pulses.

Common rules:
- `done`=1 and `frm_cnt` += 1 on the first cycle after DATA (or after CHK when `len_q`=0).
- Mismatch: in any non-ERR state, `fsm_out` != expected code forces the next state to ERR and sets `err`=1. A mismatch overrides all other transitions.
- ERR: `step3`=1, `start`=0, `step2`=0. When `fsm_out`==001 is sampled, go to IDLE. No `done`, no count.
- `err` is cleared by `err_clr`. If `err_clr` and a new mismatch occur in the same cycle, set wins.
- While `err`=1, `req_ready`=0 and no request is accepted.
- All outputs are decoded from registered state and counters only. There is no combinational path from any input to any output.
- Arithmetic: `cnt` is LEN_W bits, loaded only in CHK, never underflows. `frm_cnt` wraps from all-ones to 0.

## Timing
- Reset (`reset`=0 at an edge), from any state including mid-frame:
  - Next cycle: IDLE, `len_q`=`cnt`=0.
  - `start`=`step2`=`step3`=`busy`=`done`=`err`=0, `frm_cnt`=0, `req_ready`=1.
- Cycle numbering: cycle k is the cycle after edge k. A request is accepted at edge 0.
  - Cycle 1: START.
  - Cycle 2: WAIT.
  - Cycle 3: CHK.
  - Cycles 4..3+L: DATA, with `step3` in cycle 3+L.
  - GAP starts in cycle 4+L with `done` in that cycle.
  - `req_ready` rises in cycle 4+L+GAP_CYC.
- For L=0: GAP starts in cycle 4, and `req_ready` rises in cycle 4+GAP_CYC.
- `req_ready` is low in cycle 1, so back-to-back requests are throttled by design. `req_valid` held high through busy states is not consumed.
- L = 2^LEN_W−1 gives the maximum DATA length, with no counter wrap.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset`=0 for 2 cycles with random inputs, then release.
  - Required: all outputs at reset values, `req_ready`=1.
  - Stimulus: assert reset again in cycle 5 of a frame.
  - Required: IDLE next cycle, `frm_cnt`=0.
- Nominal frame, `req_len`=3, GAP_CYC=4, paired with a downstream FSM model:
  - `start` in cycle 1; `step2`=1 in cycle 3; `step3` only in cycle 6.
  - `done` in cycle 7, `frm_cnt`=1, `req_ready`=1 in cycle 11.
  - No `err`.
- Header-only frame, `req_len`=0:
  - `step2`=0 in cycle 3; FSM returns to 001 in cycle 4.
  - `done` in cycle 4, `req_ready` in cycle 8.
- Boundaries:
  - `req_len`=255 gives exactly 255 DATA cycles.
  - GAP_CYC=0 build: `req_ready` in cycle 4+L.
  - Preload `frm_cnt`=16'hFFFF: the next `done` gives 0.
- Mismatch in CHK: force `fsm_out`=001 in cycle 3.
  - Required: ERR in cycle 4, `err`=1, `step3`=1.
  - Required: IDLE in cycle 5 with `req_ready`=0.
  - Then `err_clr` pulse: `err`=0 and `req_ready`=1 on the next cycle.
- Stuck payload: force `fsm_out`=111 for 3 cycles after a mismatch.
  - Required: `step3` held high for those 3 cycles.
  - Required: IDLE the cycle after 001 is seen.
  - Required: `err_clr` asserted together with a mismatch leaves `err`=1.
